consmax_lut_ctrl: RTL and testbench
===================================

# consmax_lut_ctrl

LUT load and config sequencer for the ConSmax bus datapath. Owns the shared LUT write port (`lut_waddr`/`lut_wen`/`lut_wdata`) and `cfg_consmax_shift` of all ConSmax blocks. Admits upstream score traffic only when it is safe to do so, drains the datapath pipeline before any LUT rewrite, and streams 2×LUT_DEPTH entries into the two LUT banks. Sits between the host/SPI config path and `consmax_bus`.

## Interface
- `LUT_ADDR`, 4: LUT bank address width; each bank holds 2**LUT_ADDR entries.
- `LUT_DATA`, 16: LUT entry width (FP16-style: 1 sign, 8 exponent, 7 mantissa).
- `CDATA_BIT`, 8: shift config width.
- `NUM_HEAD`, 4: number of per-head valid lanes.
- `DRAIN_CYC`, 3: cycles needed for the last admitted input to clear the datapath; must be ≥ 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `load_start` in 1: single-cycle request to reload both LUTs.
- `load_busy` out 1: high whenever state ≠ IDLE.
- `load_done` out 1: one-cycle pulse after the final LUT write.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in LUT_DATA: LUT entry stream.
- `cfg_shift_in` in CDATA_BIT, `cfg_shift_wen` in 1: shift update request.
- `cfg_consmax_shift` out CDATA_BIT: applied shift, sent to the datapath.
- `lut_waddr` out LUT_ADDR+1, `lut_wen` out 1, `lut_wdata` out LUT_DATA: LUT write port.
- `in_valid` in NUM_HEAD: upstream per-head valid.
- `in_ready` out 1: upstream may present data.
- `out_valid` out NUM_HEAD: drives the datapath `idata_valid`.
- `lut_loaded` out 1: set after the first complete load.

## Operation
- States:
  - IDLE: `in_ready = lut_loaded`. `load_start` moves to DRAIN and clears the drain counter.
  - DRAIN: the drain counter increments each cycle. When it reaches DRAIN_CYC-1, move to LOAD and clear the entry counter.
  - LOAD: `wr_ready = 1`. Each handshake (`wr_valid && wr_ready`) registers one write and increments the 5-bit (LUT_ADDR+1) entry counter. The handshake that carries entry 2**(LUT_ADDR+1)-1 moves to DONE.
  - DONE: one cycle. Pulse `load_done`, set `lut_loaded`, apply any pending shift, return to IDLE.
- Entry ordering: counter values 0..LUT_DEPTH-1 write bank 0 (`lut_waddr[LUT_ADDR]=0`), which holds the low-nibble LUT. Values LUT_DEPTH..2·LUT_DEPTH-1 write bank 1. `lut_waddr` equals the counter value.
- `out_valid = in_valid & {NUM_HEAD{in_ready}}` (combinational). No valid reaches the datapath outside IDLE or before the first load.
- `load_start` is ignored outside IDLE. If `load_start` coincides with `in_valid` in IDLE, that input is still admitted on that cycle; DRAIN covers it.
- Shift config:
  - `cfg_shift_wen` in IDLE with no `in_valid` asserted: `cfg_consmax_shift` updates on the next edge.
  - Otherwise the value is latched into a pending register and a pending flag is set. The pending value is applied on the first IDLE cycle with no `in_valid`, or in DONE. A later `cfg_shift_wen` overwrites the pending value.
- `wr_data` presented outside LOAD is ignored; `wr_ready = 0` there.

## Timing
- `lut_wen`/`lut_waddr`/`lut_wdata` are registered: asserted the cycle after the handshake, for exactly one cycle per entry. Back-to-back handshakes produce back-to-back writes.
- `load_start` edge to first possible `wr_ready`: DRAIN_CYC+1 cycles.
- `load_done` asserts the cycle after the final write's `lut_wen` cycle. `in_ready` returns high the cycle after `load_done`.
- Reset values: state IDLE; all counters 0; `lut_wen = 0`, `lut_waddr = 0`, `lut_wdata = 0`; `cfg_consmax_shift = 0`; pending flag 0; `lut_loaded = 0`; `load_busy`, `load_done`, `wr_ready`, `in_ready`, `out_valid` all 0.
- Reset asserted mid-load returns to IDLE with `lut_loaded = 0`. A full reload is required before traffic is admitted again.

## Structure
- Shared package `consmax_pkg`: the state enum (IDLE/DRAIN/LOAD/DONE), the LUT_ADDR/LUT_DATA defaults, and the FP field widths shared with the datapath.
- One natural sub-module: `consmax_shift_cfg`, holding the shift register plus pending register and flag, with an apply-enable input from the FSM.

## Test plan
- Reset, then `in_valid = 4'hF`: `in_ready = 0` and `out_valid = 0` until a load completes.
- `load_start`, then 32 back-to-back entries 0x3F80+k: the `lut_wen` pulses carry `lut_waddr` 0..31 with matching data. `load_done` pulses one cycle after write 31. `lut_loaded` = 1.
- Same load with `wr_valid` toggling every other cycle: 32 writes, correct order, no duplicates. `lut_wen` is never asserted on a cycle after a non-handshake.
- `in_valid` held high, `load_start` pulsed: that cycle is passed through to `out_valid`, then `in_ready = 0`. First `wr_ready` comes 4 cycles after `load_start` (DRAIN_CYC = 3).
- `cfg_shift_wen` with value 0x05 during LOAD: `cfg_consmax_shift` stays old until the DONE cycle, then reads 0x05. A second `cfg_shift_wen` with 0x07 in IDLE with no valid applies next edge.
- `rst` asserted after 10 entries: all outputs return to reset values. `load_start` is then required, and addresses restart at 0.

Source files
------------

// File: rtl/consmax_pkg.sv
// Shared definitions for the ConSmax LUT controller and datapath.
//   - ctrl_state_t : LUT load sequencer states
//   - FP field widths of a LUT entry and default parameter values
package consmax_pkg;

    // FP16-style LUT entry: 1 sign, 8 exponent, 7 mantissa bits.
    localparam int unsigned FP_SIGN_W = 1;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_MANT_W = 7;

    localparam int unsigned LUT_ADDR_DEF  = 4;
    localparam int unsigned LUT_DATA_DEF  = FP_SIGN_W + FP_EXP_W + FP_MANT_W;
    localparam int unsigned CDATA_BIT_DEF = 8;
    localparam int unsigned NUM_HEAD_DEF  = 4;
    localparam int unsigned DRAIN_CYC_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/consmax_shift_cfg.sv
// Shift configuration holder: applied shift plus a one-deep pending slot.
// Ports:
//   clk, rst   : clock, async active-high reset
//   wen, wdata : shift update request and value
//   direct_en  : update may be applied immediately (quiet IDLE)
//   apply_en   : a pending value may be applied now (quiet IDLE or DONE)
//   shift      : applied shift value
module consmax_shift_cfg
    import consmax_pkg::*;
#(
    parameter int unsigned CDATA_BIT = CDATA_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic [CDATA_BIT-1:0] wdata,
    input  logic                 direct_en,
    input  logic                 apply_en,
    output logic [CDATA_BIT-1:0] shift
);

    logic [CDATA_BIT-1:0] pend_val;
    logic                 pend;

    // A direct write supersedes anything pending; otherwise a new request
    // replaces the pending value (after any pending apply this cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift    <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
        end else if (wen && direct_en) begin
            shift <= wdata;
            pend  <= 1'b0;
        end else begin
            if (apply_en && pend) begin
                shift <= pend_val;
                pend  <= 1'b0;
            end
            if (wen) begin
                pend_val <= wdata;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/consmax_lut_ctrl.sv
// LUT load / config sequencer for the ConSmax bus datapath.
// Drains the datapath, streams 2*2**LUT_ADDR entries into the two LUT banks
// and gates upstream score traffic until a complete load has happened.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   load_start/load_busy/load_done: reload request and status
//   wr_valid/wr_ready/wr_data     : LUT entry stream (accepted in LOAD only)
//   cfg_shift_in/cfg_shift_wen    : shift update request
//   cfg_consmax_shift             : applied shift to the datapath
//   lut_waddr/lut_wen/lut_wdata   : shared LUT write port (registered)
//   in_valid/in_ready/out_valid   : upstream admission, out_valid combinational
//   lut_loaded                    : set after the first complete load
module consmax_lut_ctrl
    import consmax_pkg::*;
#(
    parameter int unsigned LUT_ADDR  = LUT_ADDR_DEF,
    parameter int unsigned LUT_DATA  = LUT_DATA_DEF,
    parameter int unsigned CDATA_BIT = CDATA_BIT_DEF,
    parameter int unsigned NUM_HEAD  = NUM_HEAD_DEF,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    output logic                 load_busy,
    output logic                 load_done,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [LUT_DATA-1:0]  wr_data,
    input  logic [CDATA_BIT-1:0] cfg_shift_in,
    input  logic                 cfg_shift_wen,
    output logic [CDATA_BIT-1:0] cfg_consmax_shift,
    output logic [LUT_ADDR:0]    lut_waddr,
    output logic                 lut_wen,
    output logic [LUT_DATA-1:0]  lut_wdata,
    input  logic [NUM_HEAD-1:0]  in_valid,
    output logic                 in_ready,
    output logic [NUM_HEAD-1:0]  out_valid,
    output logic                 lut_loaded
);

    localparam int unsigned ENT_W = LUT_ADDR + 1;
    localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

    ctrl_state_t          state_q, state_d;
    logic [DRN_W-1:0]     drn_cnt_q, drn_cnt_d;
    logic [ENT_W-1:0]     ent_cnt_q, ent_cnt_d;
    logic                 lut_wen_d;
    logic [LUT_ADDR:0]    lut_waddr_d;
    logic [LUT_DATA-1:0]  lut_wdata_d;
    logic                 load_done_d;
    logic                 lut_loaded_d;
    logic                 in_ready_d;
    logic                 wr_ready_d;
    logic                 load_busy_d;
    logic                 shift_direct;
    logic                 shift_apply;

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        drn_cnt_d    = drn_cnt_q;
        ent_cnt_d    = ent_cnt_q;
        lut_wen_d    = 1'b0;
        lut_waddr_d  = lut_waddr;
        lut_wdata_d  = lut_wdata;
        load_done_d  = 1'b0;
        lut_loaded_d = lut_loaded;
        shift_direct = 1'b0;
        shift_apply  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid == '0) begin
                    shift_direct = 1'b1;
                    shift_apply  = 1'b1;
                end
                if (load_start) begin
                    state_d   = ST_DRAIN;
                    drn_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                drn_cnt_d = drn_cnt_q + DRN_W'(1);
                if (drn_cnt_q == DRN_LAST) begin
                    state_d   = ST_LOAD;
                    ent_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (wr_valid) begin
                    lut_wen_d   = 1'b1;
                    lut_waddr_d = ent_cnt_q;
                    lut_wdata_d = wr_data;
                    ent_cnt_d   = ent_cnt_q + ENT_W'(1);
                    if (&ent_cnt_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                load_done_d  = 1'b1;
                lut_loaded_d = 1'b1;
                shift_apply  = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // in_ready only after a full IDLE cycle, so it lags load_done by one.
        in_ready_d  = (state_q == ST_IDLE) && (state_d == ST_IDLE) && lut_loaded;
        wr_ready_d  = (state_d == ST_LOAD);
        load_busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            drn_cnt_q  <= '0;
            ent_cnt_q  <= '0;
            lut_wen    <= 1'b0;
            lut_waddr  <= '0;
            lut_wdata  <= '0;
            load_done  <= 1'b0;
            lut_loaded <= 1'b0;
            in_ready   <= 1'b0;
            wr_ready   <= 1'b0;
            load_busy  <= 1'b0;
        end else begin
            state_q    <= state_d;
            drn_cnt_q  <= drn_cnt_d;
            ent_cnt_q  <= ent_cnt_d;
            lut_wen    <= lut_wen_d;
            lut_waddr  <= lut_waddr_d;
            lut_wdata  <= lut_wdata_d;
            load_done  <= load_done_d;
            lut_loaded <= lut_loaded_d;
            in_ready   <= in_ready_d;
            wr_ready   <= wr_ready_d;
            load_busy  <= load_busy_d;
        end
    end

    // Admission gate toward the datapath idata_valid.
    assign out_valid = in_valid & {NUM_HEAD{in_ready}};

    consmax_shift_cfg #(
        .CDATA_BIT (CDATA_BIT)
    ) u_shift_cfg (
        .clk       (clk),
        .rst       (rst),
        .wen       (cfg_shift_wen),
        .wdata     (cfg_shift_in),
        .direct_en (shift_direct),
        .apply_en  (shift_apply),
        .shift     (cfg_consmax_shift)
    );

endmodule

// File: tb/tb_consmax_lut_ctrl.sv
// Self-checking bench for consmax_lut_ctrl.
module tb_consmax_lut_ctrl;

    localparam int DRAIN_CYC = 3;
    localparam int N_ENT     = 32;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        load_busy;
    logic        load_done;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [7:0]  cfg_shift_in;
    logic        cfg_shift_wen;
    logic [7:0]  cfg_consmax_shift;
    logic [4:0]  lut_waddr;
    logic        lut_wen;
    logic [15:0] lut_wdata;
    logic [3:0]  in_valid;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic        lut_loaded;

    consmax_lut_ctrl #(
        .LUT_ADDR  (4),
        .LUT_DATA  (16),
        .CDATA_BIT (8),
        .NUM_HEAD  (4),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .load_start        (load_start),
        .load_busy         (load_busy),
        .load_done         (load_done),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .cfg_shift_in      (cfg_shift_in),
        .cfg_shift_wen     (cfg_shift_wen),
        .cfg_consmax_shift (cfg_consmax_shift),
        .lut_waddr         (lut_waddr),
        .lut_wen           (lut_wen),
        .lut_wdata         (lut_wdata),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .lut_loaded        (lut_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the bench expects from the specification.
    logic        m_loaded;
    logic [7:0]  m_shift;
    logic        m_pend;
    logic [7:0]  m_pend_val;

    logic [20:0] exp_q[$];
    logic [20:0] got_q[$];

    // Record every LUT write as {addr, data}.
    always @(posedge clk) begin
        if (lut_wen === 1'b1) got_q.push_back({lut_waddr, lut_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_load_busy", 32'(load_busy), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_lut_wen", 32'(lut_wen), 0);
        chk("rst_lut_waddr", 32'(lut_waddr), 0);
        chk("rst_lut_wdata", 32'(lut_wdata), 0);
        chk("rst_shift", 32'(cfg_consmax_shift), 0);
        chk("rst_lut_loaded", 32'(lut_loaded), 0);
    endtask

    // mode 0: back-to-back 0x3F80+k; 1: valid toggles; 2: random valid/data.
    // n_stop < N_ENT aborts after that many entries (for the reset test).
    // shift_at >= 0 issues a shift request on that LOAD cycle.
    task automatic do_load(input int mode, input int n_stop, input int shift_at,
                           input logic [7:0] shift_val);
        int          k;
        int          cl;
        logic        hs_prev;
        logic        tog;
        logic        v;
        logic [15:0] d;
        exp_q.delete();
        got_q.delete();

        // Request cycle: input is still admitted if already loaded.
        load_start = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 16'hDEAD;
        #1;
        chk("ov_at_start", 32'(out_valid), m_loaded ? 32'(in_valid) : 0);
        tick();
        load_start = 1'b0;

        for (int i = 1; i <= DRAIN_CYC; i++) begin
            chk("drain_wr_ready", 32'(wr_ready), 0);
            chk("drain_busy", 32'(load_busy), 1);
            chk("drain_in_ready", 32'(in_ready), 0);
            chk("drain_lut_wen", 32'(lut_wen), 0);
            chk("drain_ov", 32'(out_valid), 0);
            tick();
        end

        k = 0; cl = 0; hs_prev = 1'b0; tog = 1'b1;
        while (k < n_stop) begin
            chk("load_wr_ready", 32'(wr_ready), 1);
            chk("wen_follows_hs", 32'(lut_wen), 32'(hs_prev));
            chk("load_ov", 32'(out_valid), 0);
            chk("load_shift", 32'(cfg_consmax_shift), 32'(m_shift));
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = (mode == 0) ? 16'(16'h3F80 + k) : 16'($urandom);
            wr_valid = v;
            wr_data  = d;
            if (cl == shift_at) begin
                cfg_shift_wen = 1'b1;
                cfg_shift_in  = shift_val;
                m_pend        = 1'b1;
                m_pend_val    = shift_val;
            end
            if (v) begin
                exp_q.push_back({5'(k), d});
                k++;
            end
            hs_prev = v;
            cl++;
            tick();
            cfg_shift_wen = 1'b0;
        end
        wr_valid = 1'b0;
        if (n_stop < N_ENT) return;

        // DONE: final write visible, load_done not yet.
        chk("done_lut_wen", 32'(lut_wen), 1);
        chk("done_wr_ready", 32'(wr_ready), 0);
        chk("done_load_done", 32'(load_done), 0);
        chk("done_busy", 32'(load_busy), 1);
        chk("done_shift_old", 32'(cfg_consmax_shift), 32'(m_shift));
        tick();

        if (m_pend) begin
            m_shift = m_pend_val;
            m_pend  = 1'b0;
        end
        m_loaded = 1'b1;
        chk("load_done_pulse", 32'(load_done), 1);
        chk("lut_loaded_set", 32'(lut_loaded), 1);
        chk("in_ready_lag", 32'(in_ready), 0);
        chk("post_lut_wen", 32'(lut_wen), 0);
        chk("post_busy", 32'(load_busy), 0);
        chk("post_shift", 32'(cfg_consmax_shift), 32'(m_shift));
        tick();

        chk("load_done_one", 32'(load_done), 0);
        chk("in_ready_back", 32'(in_ready), 1);
        chk("ov_after_load", 32'(out_valid), 32'(in_valid));

        chk("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("write_entry", 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        logic [7:0] r;

        rst = 1'b1;
        load_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
        cfg_shift_in = '0; cfg_shift_wen = 1'b0; in_valid = 4'hF;
        m_loaded = 1'b0; m_shift = '0; m_pend = 1'b0; m_pend_val = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;

        // Not loaded yet: traffic and stray writes are blocked.
        wr_valid = 1'b1; wr_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("preload_in_ready", 32'(in_ready), 0);
            chk("preload_ov", 32'(out_valid), 0);
            chk("preload_wr_ready", 32'(wr_ready), 0);
            chk("preload_lut_wen", 32'(lut_wen), 0);
        end
        wr_valid = 1'b0;

        // Shift request while in_valid is high is held until a quiet cycle.
        r = 8'($urandom_range(1, 255));
        cfg_shift_wen = 1'b1; cfg_shift_in = r;
        tick();
        cfg_shift_wen = 1'b0;
        chk("shift_pending_a", 32'(cfg_consmax_shift), 0);
        tick();
        chk("shift_pending_b", 32'(cfg_consmax_shift), 0);
        in_valid = 4'h0;
        tick();
        m_shift = r;
        chk("shift_pending_applied", 32'(cfg_consmax_shift), 32'(m_shift));

        // Back-to-back load of 0x3F80+k.
        do_load(0, N_ENT, -1, 8'h00);

        // Admitted traffic in IDLE.
        for (int i = 0; i < 8; i++) begin
            in_valid = 4'($urandom);
            #1;
            chk("idle_in_ready", 32'(in_ready), 1);
            chk("idle_ov", 32'(out_valid), 32'(in_valid));
            tick();
        end

        // in_valid held high across load_start, toggling write valid.
        in_valid = 4'hF;
        do_load(1, N_ENT, -1, 8'h00);

        // Random load with a shift request mid-LOAD.
        in_valid = 4'h0;
        do_load(2, N_ENT, 2, 8'h05);
        chk("shift_0x05", 32'(cfg_consmax_shift), 32'h05);

        // Quiet IDLE: direct update on the next edge.
        cfg_shift_wen = 1'b1; cfg_shift_in = 8'h07;
        tick();
        cfg_shift_wen = 1'b0;
        m_shift = 8'h07;
        chk("shift_direct", 32'(cfg_consmax_shift), 32'(m_shift));

        // Busy IDLE: deferred until in_valid drops.
        r = 8'($urandom_range(8, 255));
        in_valid = 4'h3; cfg_shift_wen = 1'b1; cfg_shift_in = r;
        #1;
        chk("busy_idle_ov", 32'(out_valid), 32'h3);
        tick();
        cfg_shift_wen = 1'b0;
        chk("shift_deferred", 32'(cfg_consmax_shift), 32'(m_shift));
        in_valid = 4'h0;
        tick();
        m_shift = r;
        chk("shift_deferred_applied", 32'(cfg_consmax_shift), 32'(m_shift));

        // Reset after 10 entries.
        do_load(0, 10, -1, 8'h00);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        tick();
        rst = 1'b0;
        m_loaded = 1'b0; m_shift = '0; m_pend = 1'b0;
        in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_in_ready", 32'(in_ready), 0);
            chk("postrst_ov", 32'(out_valid), 0);
            chk("postrst_loaded", 32'(lut_loaded), 0);
            chk("postrst_wr_ready", 32'(wr_ready), 0);
        end

        // Full reload restarts at address 0.
        do_load(2, N_ENT, -1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
